// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle barrel-less shifter for the EX stage. It executes SLL, SRL and
// SRA one bit position per clock. The pipeline stalls on `busy`. When the
// result is ready, `sel`/`done` steer the result multiplexer to `shiftOut`
// for exactly one cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active low
//   start     in   request pulse, sampled only in IDLE
//   funct     in   6'b000000 SLL, 6'b000010 SRL, 6'b000011 SRA
//   dataIn    in   operand to shift (WIDTH)
//   shamt     in   shift amount 0..WIDTH-1 (SHW)
//   shiftOut  out  result register (WIDTH)
//   sel       out  result mux select, 1 = shift path
//   done      out  one-cycle completion pulse, same timing as sel
//   busy      out  stall request, high in SHIFT and DONE
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] shiftOut,
    output logic             sel,
    output logic             done,
    output logic             busy
);

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Request decode: only the three supported codes are accepted.
    logic op_valid;
    op_t  op_dec;

    always_comb begin
        op_valid = 1'b1;
        op_dec   = OP_SLL;
        unique case (funct)
            FUNCT_SLL: op_dec = OP_SLL;
            FUNCT_SRL: op_dec = OP_SRL;
            FUNCT_SRA: op_dec = OP_SRA;
            default:   op_valid = 1'b0;
        endcase
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        op_d    = op_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start && op_valid) begin
                    shift_d = dataIn;
                    cnt_d   = shamt;
                    op_d    = op_dec;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    unique case (op_q)
                        OP_SRL:  shift_d = {1'b0, shift_q[WIDTH-1:1]};
                        OP_SRA:  shift_d = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
                        default: shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    endcase
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode, so they
        // match a Moore decode of state_q with no input-to-output path.
        sel_d  = (state_d == DONE);
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            shift_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign shiftOut = shift_q;
    assign sel      = sel_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
